// File: rtl/conv_encoder_framer.sv
// -----------------------------------------------------------------------------
// conv_encoder_framer
//
// Rate-1/2, constraint-length-4 (8-state) convolutional encoder with frame
// control. A frame of frame_len information bits is accepted over a
// din/din_valid/din_ready handshake. Each accepted bit produces one registered
// 2-bit symbol. Three zero tail bits are then appended, so every frame starts
// and ends in trellis state 000.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      frame request, sampled only while idle
//   frame_len  information bits in the frame, latched on start (0 is legal)
//   din        information bit
//   din_valid  din is valid this cycle
//   din_ready  encoder accepts din this cycle (high only in DATA)
//   enc_out    coded symbol {G0 parity, G1 parity}, registered
//   enc_valid  enc_out valid this cycle, registered
//   busy       high in every state except IDLE
//   done       one-cycle pulse coincident with the final tail symbol
// -----------------------------------------------------------------------------
module conv_encoder_framer #(
    parameter int         LEN_W = 10,
    parameter logic [3:0] G0    = 4'b1111,
    parameter logic [3:0] G1    = 4'b1101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [1:0]       enc_out,
    output logic             enc_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DATA = 2'b01;
    localparam logic [1:0] ST_TAIL = 2'b10;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    // Parity of the tapped register bits; r = {input, s[2], s[1], s[0]}.
    function automatic logic [1:0] encode_sym(input logic b, input logic [2:0] s);
        logic [3:0] r;
        r = {b, s};
        return {^(r & G0), ^(r & G1)};
    endfunction

    logic [1:0]       state_r;
    logic [LEN_W-1:0] bit_cnt_r;
    logic [1:0]       tail_cnt_r;
    logic [2:0]       shift_r;
    logic [1:0]       enc_out_r;
    logic             enc_valid_r;
    logic             done_r;

    logic             enc_bit_s;
    logic [1:0]       sym_s;

    // Bit entering the encoder: din in DATA, forced zero while flushing the tail.
    always_comb begin
        enc_bit_s = 1'b0;
        if (state_r == ST_DATA) begin
            enc_bit_s = din;
        end else begin
            enc_bit_s = 1'b0;
        end
        sym_s = encode_sym(enc_bit_s, shift_r);
    end

    // Frame FSM, shift register, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= CNT_ZERO;
            tail_cnt_r  <= 2'd0;
            shift_r     <= 3'b000;
            enc_out_r   <= 2'b00;
            enc_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // Valid and done are single-cycle unless a branch below re-asserts them;
            // enc_out keeps its last value when nothing is encoded.
            enc_valid_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bit_cnt_r  <= frame_len;
                        shift_r    <= 3'b000;
                        tail_cnt_r <= 2'd0;
                        state_r    <= (frame_len != CNT_ZERO) ? ST_DATA : ST_TAIL;
                    end
                end
                ST_DATA: begin
                    // din_ready is 1 throughout DATA, so din_valid alone means acceptance.
                    if (din_valid) begin
                        enc_out_r   <= sym_s;
                        enc_valid_r <= 1'b1;
                        shift_r     <= {enc_bit_s, shift_r[2:1]};
                        bit_cnt_r   <= bit_cnt_r - CNT_ONE;
                        if (bit_cnt_r == CNT_ONE) begin
                            state_r    <= ST_TAIL;
                            tail_cnt_r <= 2'd0;
                        end
                    end
                end
                ST_TAIL: begin
                    enc_out_r   <= sym_s;
                    enc_valid_r <= 1'b1;
                    shift_r     <= {1'b0, shift_r[2:1]};
                    if (tail_cnt_r == 2'd2) begin
                        tail_cnt_r <= 2'd0;
                        state_r    <= ST_IDLE;
                        done_r     <= 1'b1;
                    end else begin
                        tail_cnt_r <= tail_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign din_ready = (state_r == ST_DATA);
    assign busy      = (state_r != ST_IDLE);
    assign enc_out   = enc_out_r;
    assign enc_valid = enc_valid_r;
    assign done      = done_r;

endmodule
